// File: rtl/down_count_pkg.sv
// Shared types and helpers for the ripple down-counter monitor.
package down_count_pkg;

    // Lock state of the monitor.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_e;

    // Value minus one, wrapped to the low 'width' bits.
    function automatic logic [31:0] dec_mod(input logic [31:0] value,
                                            input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value - 32'd1) & mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    // Next count: clear wins, otherwise saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = sat_inc(count_q);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/down_count_monitor.sv
// Synchronous monitor for a ripple down-counter: two-flop sampling with
// equal-sample deglitch, legal -1 step checking, lock FSM and event counters.
module down_count_monitor
    import down_count_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned WRAP_W       = 8,
    parameter int unsigned ERR_W        = 8,
    parameter int unsigned RELOCK_STEPS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              clr,
    input  logic [WIDTH-1:0]  cfg_match,
    output logic [WIDTH-1:0]  cnt_q,
    output logic              cnt_valid,
    output logic              locked,
    output logic              wrap_pulse,
    output logic              match_pulse,
    output logic              step_err,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [ERR_W-1:0]  err_count
);

    localparam int unsigned RUN_W = $clog2(RELOCK_STEPS + 1);

    // Sample pipeline.
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    // Marks which sample stages hold a real sample of cnt_in. The reset
    // value of s1/s2 is not a sample, so it must never be accepted as a
    // stable count (otherwise a spurious 0 would be captured after reset).
    logic [1:0]       samp_vld_q, samp_vld_d;

    // Clean count and FSM.
    logic [WIDTH-1:0] cnt_d;
    state_e           state_q, state_d;
    logic [RUN_W-1:0] good_run_q, good_run_d;
    logic [RUN_W-1:0] run_inc;
    logic             cnt_valid_q, cnt_valid_d;
    logic             locked_q, locked_d;
    logic             wrap_q, wrap_d;
    logic             match_q, match_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] cnt_dec;
    logic             upd;
    logic             legal;
    logic             at_zero;

    // Sample shift and update qualification.
    always_comb begin
        s1_d       = cnt_in;
        s2_d       = s1_q;
        samp_vld_d = {samp_vld_q[0], 1'b1};
        cnt_dec    = WIDTH'(dec_mod(32'(cnt_q), WIDTH));
        upd        = samp_vld_q[1] && (s1_q == s2_q) &&
                     ((state_q == IDLE) || (s2_q != cnt_q));
        legal      = (s2_q == cnt_dec);
        at_zero    = (cnt_q == '0);
        run_inc    = good_run_q + RUN_W'(1);
    end

    // Lock FSM next state, clean count and event pulses.
    always_comb begin
        cnt_d       = cnt_q;
        state_d     = state_q;
        good_run_d  = good_run_q;
        cnt_valid_d = cnt_valid_q;
        wrap_d      = 1'b0;
        match_d     = 1'b0;
        err_d       = 1'b0;
        if (upd) begin
            cnt_d   = s2_q;
            match_d = (s2_q == cfg_match);
            case (state_q)
                IDLE: begin
                    // First capture: nothing to compare against yet.
                    cnt_valid_d = 1'b1;
                    good_run_d  = '0;
                    state_d     = LOCKED;
                end
                LOCKED: begin
                    if (!legal) begin
                        err_d      = 1'b1;
                        good_run_d = '0;
                        state_d    = FAULT;
                    end else begin
                        wrap_d = at_zero;
                    end
                end
                FAULT: begin
                    if (!legal) begin
                        err_d      = 1'b1;
                        good_run_d = '0;
                    end else begin
                        wrap_d = at_zero;
                        if (run_inc == RUN_W'(RELOCK_STEPS)) begin
                            good_run_d = '0;
                            state_d    = LOCKED;
                        end else begin
                            good_run_d = run_inc;
                        end
                    end
                end
                default: begin
                    good_run_d = '0;
                    state_d    = IDLE;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    // All monitor state; reset returns everything to the pre-capture state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            samp_vld_q  <= '0;
            cnt_q       <= '0;
            state_q     <= IDLE;
            good_run_q  <= '0;
            cnt_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            wrap_q      <= 1'b0;
            match_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            samp_vld_q  <= samp_vld_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            good_run_q  <= good_run_d;
            cnt_valid_q <= cnt_valid_d;
            locked_q    <= locked_d;
            wrap_q      <= wrap_d;
            match_q     <= match_d;
            err_q       <= err_d;
        end
    end

    assign cnt_valid   = cnt_valid_q;
    assign locked      = locked_q;
    assign wrap_pulse  = wrap_q;
    assign match_pulse = match_q;
    assign step_err    = err_q;

    // Counters advance on the same edge that raises the matching pulse.
    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wrap_d),
        .clr   (clr),
        .count (wrap_count)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_d),
        .clr   (clr),
        .count (err_count)
    );

endmodule

// File: tb/tb_down_count_monitor.sv
// Scoreboard bench for down_count_monitor (WIDTH=4, WRAP_W=ERR_W=8, RELOCK_STEPS=4).
module tb_down_count_monitor;

    localparam int RELOCK = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] cnt_in;
    logic [3:0] cfg_match;
    logic [3:0] cnt_q;
    logic       cnt_valid;
    logic       locked;
    logic       wrap_pulse;
    logic       match_pulse;
    logic       step_err;
    logic [7:0] wrap_count;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    down_count_monitor #(
        .WIDTH(4), .WRAP_W(8), .ERR_W(8), .RELOCK_STEPS(RELOCK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .clr         (clr),
        .cfg_match   (cfg_match),
        .cnt_q       (cnt_q),
        .cnt_valid   (cnt_valid),
        .locked      (locked),
        .wrap_pulse  (wrap_pulse),
        .match_pulse (match_pulse),
        .step_err    (step_err),
        .wrap_count  (wrap_count),
        .err_count   (err_count)
    );

    // One accepted count update and what it should have caused.
    typedef struct packed {
        logic [3:0] cnt;
        logic       wrap;
        logic       match;
        logic       err;
        logic       locked;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level reference state.
    bit         m_have;
    bit         m_fault;
    logic [3:0] m_last;
    int         m_run;
    int         m_wc;
    int         m_ec;

    logic [3:0] last_cnt;
    logic       last_valid;

    task automatic model_reset();
        m_have  = 0;
        m_fault = 0;
        m_last  = '0;
        m_run   = 0;
        m_wc    = 0;
        m_ec    = 0;
    endtask

    // Advance one clock and record any visible update event.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst && (wrap_pulse || match_pulse || step_err ||
                     cnt_q !== last_cnt || (cnt_valid && !last_valid))) begin
            obs_q.push_back(ev_t'{cnt_q, wrap_pulse, match_pulse, step_err, locked});
        end
        last_cnt   = cnt_q;
        last_valid = cnt_valid;
    endtask

    // Predict the outcome of accepting value v.
    task automatic push_expect(input logic [3:0] v);
        ev_t e;
        bit  legal;
        e.cnt   = v;
        e.wrap  = 1'b0;
        e.err   = 1'b0;
        e.match = (v == cfg_match);
        if (!m_have) begin
            m_have  = 1;
            m_fault = 0;
            m_run   = 0;
        end else begin
            legal = (v == 4'(m_last - 4'd1));
            if (legal) begin
                e.wrap = (m_last == 4'd0);
                if (m_fault) begin
                    m_run++;
                    if (m_run == RELOCK) begin
                        m_fault = 0;
                        m_run   = 0;
                    end
                end
            end else begin
                e.err   = 1'b1;
                m_fault = 1;
                m_run   = 0;
            end
        end
        e.locked = !m_fault;
        m_last   = v;
        if (e.wrap && m_wc < 255) m_wc++;
        if (e.err && m_ec < 255) m_ec++;
        exp_q.push_back(e);
    endtask

    // Present v on cnt_in for n clocks; two or more clocks make it stable.
    task automatic hold(input logic [3:0] v, input int n);
        cnt_in = v;
        if (n >= 2 && (!m_have || v != m_last)) push_expect(v);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; cnt_in = 4'd0; cfg_match = 4'd0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        n_checks++;
        if ({cnt_q, cnt_valid, locked} !== 6'd0) $display("FAIL reset_state: got cnt=%0d valid=%b locked=%b, required 0/0/0", cnt_q, cnt_valid, locked);
        else n_pass++;
        n_checks++;
        if ({wrap_pulse, match_pulse, step_err, wrap_count, err_count} !== 19'd0) $display("FAIL reset_pulses: got w=%b m=%b e=%b wc=%0d ec=%0d, required all 0", wrap_pulse, match_pulse, step_err, wrap_count, err_count);
        else n_pass++;
        cnt_in = 4'd5;
        push_expect(4'd5);
        tick(); tick();
        n_checks++;
        if (cnt_valid !== 1'b0) $display("FAIL capture_early: got cnt_valid=%b, required 0", cnt_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({cnt_q, cnt_valid, locked, step_err, wrap_pulse} !== {4'd5, 1'b1, 1'b1, 1'b0, 1'b0}) $display("FAIL capture_5: got cnt=%0d valid=%b locked=%b err=%b wrap=%b, required 5 1 1 0 0", cnt_q, cnt_valid, locked, step_err, wrap_pulse);
        else n_pass++;
        hold(4'd5, 2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL reset_events: got %0d events, required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL reset_event: got cnt=%0d wmel=%b, required cnt=%0d wmel=%b", o.cnt, o[3:0], e.cnt, e[3:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap_sequence();
        hold(4'd4, 3); hold(4'd3, 3); hold(4'd2, 2); hold(4'd1, 2);
        hold(4'd0, 3); hold(4'd15, 2); hold(4'd14, 3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL wrap_events: got %0d events, required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL wrap_event: got cnt=%0d wmel=%b, required cnt=%0d wmel=%b", o.cnt, o[3:0], e.cnt, e[3:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
        n_checks++;
        if ({wrap_count, err_count, locked} !== {8'd1, 8'd0, 1'b1}) $display("FAIL wrap_counts: got wc=%0d ec=%0d locked=%b, required 1 0 1", wrap_count, err_count, locked);
        else n_pass++;
    endtask

    task automatic test_glitch();
        hold(4'd13, 3); hold(4'd12, 3); hold(4'd11, 3); hold(4'd10, 3);
        hold(4'd9, 3); hold(4'd4, 1); hold(4'd9, 4);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL glitch_events: got %0d events, required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL glitch_event: got cnt=%0d wmel=%b, required cnt=%0d wmel=%b", o.cnt, o[3:0], e.cnt, e[3:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
        n_checks++;
        if ({cnt_q, err_count} !== {4'd9, 8'd0}) $display("FAIL glitch_hold: got cnt=%0d ec=%0d, required 9 0", cnt_q, err_count);
        else n_pass++;
    endtask

    task automatic test_fault_relock();
        hold(4'd6, 3);
        n_checks++;
        if ({locked, err_count} !== {1'b0, 8'd1}) $display("FAIL fault_entry: got locked=%b ec=%0d, required 0 1", locked, err_count);
        else n_pass++;
        hold(4'd5, 3); hold(4'd4, 3); hold(4'd3, 3);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL relock_early: got locked=%b after 3 legal steps, required 0", locked);
        else n_pass++;
        hold(4'd2, 3);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL relock: got locked=%b after 4 legal steps, required 1", locked);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL relock_events: got %0d events, required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL relock_event: got cnt=%0d wmel=%b, required cnt=%0d wmel=%b", o.cnt, o[3:0], e.cnt, e[3:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_match();
        int n_match;
        hold(4'd1, 3); hold(4'd0, 3); hold(4'd15, 3); hold(4'd14, 3);
        hold(4'd13, 3); hold(4'd12, 3); hold(4'd11, 3); hold(4'd10, 3); hold(4'd9, 3);
        obs_q.delete(); exp_q.delete();
        cfg_match = 4'd7;
        hold(4'd8, 3); hold(4'd7, 3); hold(4'd6, 3);
        n_match = 0;
        foreach (obs_q[i]) if (obs_q[i].match) n_match++;
        n_checks++;
        if (n_match != 1) $display("FAIL match_count: got %0d match pulses, required 1", n_match);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL match_events: got %0d events, required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL match_event: got cnt=%0d wmel=%b, required cnt=%0d wmel=%b", o.cnt, o[3:0], e.cnt, e[3:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        for (int v = 5; v >= 0; v--) hold(4'(v), 3);
        for (int i = 0; i < 300; i++) begin
            hold(4'd15, 2);
            hold(4'd0, 2);
        end
        hold(4'd0, 2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL sat_events: got %0d events, required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL sat_event: got cnt=%0d wmel=%b, required cnt=%0d wmel=%b", o.cnt, o[3:0], e.cnt, e[3:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
        n_checks++;
        if (wrap_count !== 8'hFF) $display("FAIL wrap_saturate: got wc=%0d, required 255", wrap_count);
        else n_pass++;
        n_checks++;
        if (err_count !== 8'(m_ec)) $display("FAIL err_saturate: got ec=%0d, required %0d", err_count, m_ec);
        else n_pass++;
    endtask

    task automatic test_clr_on_wrap();
        hold(4'd15, 2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_wc = 0;
        m_ec = 0;
        n_checks++;
        if ({wrap_pulse, wrap_count, err_count} !== {1'b1, 8'd0, 8'd0}) $display("FAIL clr_on_wrap: got wrap=%b wc=%0d ec=%0d, required 1 0 0", wrap_pulse, wrap_count, err_count);
        else n_pass++;
        hold(4'd14, 3);
        n_checks++;
        if ({cnt_q, wrap_count} !== {4'd14, 8'd0}) $display("FAIL clr_after: got cnt=%0d wc=%0d, required 14 0", cnt_q, wrap_count);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL clr_events: got %0d events, required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL clr_event: got cnt=%0d wmel=%b, required cnt=%0d wmel=%b", o.cnt, o[3:0], e.cnt, e[3:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_rst_in_fault();
        hold(4'd7, 3);
        n_checks++;
        if ({locked, err_count} !== {1'b0, 8'd1}) $display("FAIL pre_rst_fault: got locked=%b ec=%0d, required 0 1", locked, err_count);
        else n_pass++;
        obs_q.delete(); exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        n_checks++;
        if ({cnt_q, cnt_valid, locked, wrap_pulse, match_pulse, step_err, wrap_count, err_count} !== 25'd0) $display("FAIL rst_fault_state: got cnt=%0d v=%b l=%b w=%b m=%b e=%b wc=%0d ec=%0d, required all 0", cnt_q, cnt_valid, locked, wrap_pulse, match_pulse, step_err, wrap_count, err_count);
        else n_pass++;
        hold(4'd3, 3);
        n_checks++;
        if ({cnt_q, locked, err_count} !== {4'd3, 1'b1, 8'd0}) $display("FAIL rst_recapture: got cnt=%0d locked=%b ec=%0d, required 3 1 0", cnt_q, locked, err_count);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL rst_events: got %0d events, required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL rst_event: got cnt=%0d wmel=%b, required cnt=%0d wmel=%b", o.cnt, o[3:0], e.cnt, e[3:0]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_hold_const();
        hold(4'd3, 8);
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL hold_const: got %0d events while input steady, required 0", obs_q.size());
        else n_pass++;
        n_checks++;
        if ({cnt_q, locked, wrap_pulse, match_pulse, step_err} !== {4'd3, 1'b1, 3'b000}) $display("FAIL hold_state: got cnt=%0d l=%b w=%b m=%b e=%b, required 3 1 0 0 0", cnt_q, locked, wrap_pulse, match_pulse, step_err);
        else n_pass++;
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        last_cnt   = '0;
        last_valid = 1'b0;
        model_reset();
        test_reset();
        test_wrap_sequence();
        test_glitch();
        test_fault_relock();
        test_match();
        test_saturation();
        test_clr_on_wrap();
        test_rst_in_fault();
        test_hold_const();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
